// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - direction codes and FSM state encoding shared with the player module
package bm_pkg;

   localparam logic [1:0] CD_U = 2'b00;
   localparam logic [1:0] CD_R = 2'b01;
   localparam logic [1:0] CD_D = 2'b10;
   localparam logic [1:0] CD_L = 2'b11;

   // ACT_* states carry their direction code in the low bits; bit 2 marks IDLE.
   typedef logic [2:0] bm_state_t;
   localparam bm_state_t ST_IDLE  = 3'b100;
   localparam bm_state_t ST_ACT_U = {1'b0, CD_U};
   localparam bm_state_t ST_ACT_R = {1'b0, CD_R};
   localparam bm_state_t ST_ACT_D = {1'b0, CD_D};
   localparam bm_state_t ST_ACT_L = {1'b0, CD_L};

   function automatic bm_state_t act_state(input logic [1:0] code);
      return {1'b0, code};
   endfunction

endpackage

// File: rtl/bm_if.sv
// rtl/bm_if.sv - board buttons in, player-movement levels out
interface bm_if;
   logic       btn_l;
   logic       btn_r;
   logic       btn_u;
   logic       btn_d;
   logic       btn_c;
   logic       gameover;
   logic       L;
   logic       R;
   logic       U;
   logic       D;
   logic [1:0] current_dir;
   logic       bomb_req;

   modport master (
      output btn_l, btn_r, btn_u, btn_d, btn_c, gameover,
      input  L, R, U, D, current_dir, bomb_req
   );

   modport slave (
      input  btn_l, btn_r, btn_u, btn_d, btn_c, gameover,
      output L, R, U, D, current_dir, bomb_req
   );
endinterface

// File: rtl/bm_debounce.sv
// rtl/bm_debounce.sv - 2-flop synchroniser plus counter debouncer with rise/fall pulses
module bm_debounce #(
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
            stable <= sync2;
            cnt    <= '0;
            rise   <= sync2;
            fall   <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bm_controller.sv
// rtl/bm_controller.sv - debounced buttons to L/R/U/D + current_dir, last-pressed-wins
// Optional bomb path enabled by defining BM_CTRL_BOMB_EN.
module bm_controller
   import bm_pkg::*;
#(
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic clk,
   input  logic reset,
   bm_if.slave  io
);

   // Buttons indexed by their direction code, so index order is also priority order.
   logic [3:0] raw;
   logic [3:0] stable;
   logic [3:0] rise;
   logic [3:0] fall;
   bm_state_t  state;
   bm_state_t  next_state;

   assign raw = {io.btn_l, io.btn_d, io.btn_r, io.btn_u};

   for (genvar i = 0; i < 4; i++) begin : g_db
      bm_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
         .clk    (clk),
         .reset  (reset),
         .raw    (raw[i]),
         .stable (stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   always_comb begin
      next_state = state;
      if (!state[2] && fall[state[1:0]]) begin
         next_state = ST_IDLE;
         for (int i = 3; i >= 0; i--) begin
            if (stable[i]) next_state = act_state(2'(i));
         end
      end
      if (|rise) begin
         for (int i = 3; i >= 0; i--) begin
            if (rise[i]) next_state = act_state(2'(i));
         end
      end
   end

   // Outputs decode next_state so they land on the same edge as the state update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         io.L           <= 1'b0;
         io.R           <= 1'b0;
         io.U           <= 1'b0;
         io.D           <= 1'b0;
         io.current_dir <= CD_D;
      end else begin
         state <= next_state;
         io.U  <= !io.gameover && (next_state == ST_ACT_U);
         io.R  <= !io.gameover && (next_state == ST_ACT_R);
         io.D  <= !io.gameover && (next_state == ST_ACT_D);
         io.L  <= !io.gameover && (next_state == ST_ACT_L);
         if (!io.gameover && !next_state[2]) io.current_dir <= next_state[1:0];
      end
   end

`ifdef BM_CTRL_BOMB_EN
   logic c_stable;
   logic c_rise;
   logic c_fall;

   bm_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_c (
      .clk    (clk),
      .reset  (reset),
      .raw    (io.btn_c),
      .stable (c_stable),
      .rise   (c_rise),
      .fall   (c_fall)
   );

   logic unused_c;
   assign unused_c = c_stable ^ c_fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) io.bomb_req <= 1'b0;
      else       io.bomb_req <= c_rise && !io.gameover;
   end
`else
   logic unused_c;
   assign unused_c    = io.btn_c;
   assign io.bomb_req = 1'b0;
`endif

endmodule

// File: tb/tb_bm_controller.sv
// tb/tb_bm_controller.sv - random + directed stimulus, reference model feeding a scoreboard
module tb_bm_controller;

   localparam int DB = 4;
`ifdef BM_CTRL_BOMB_EN
   localparam bit BOMB = 1'b1;
`else
   localparam bit BOMB = 1'b0;
`endif

   localparam bit [4:0] BU = 5'd1, BR = 5'd2, BD = 5'd4, BL = 5'd8, BC = 5'd16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bm_if bus();

   bm_controller #(.DB_CYCLES(DB), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   typedef logic [6:0] exp_t;   // {L,R,U,D,dir[1:0],bomb}
   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model; button index = direction code (U=0,R=1,D=2,L=3), C=4.
   bit        m_d1[5], m_d2[5], m_stable[5], m_rise[5], m_fall[5];
   int        m_run[5];
   int        m_active;
   bit [1:0]  m_dir;
   exp_t      pend;

   function automatic void model_reset();
      for (int b = 0; b < 5; b++) begin
         m_d1[b] = 0; m_d2[b] = 0; m_stable[b] = 0;
         m_rise[b] = 0; m_fall[b] = 0; m_run[b] = 0;
      end
      m_active = -1;
      m_dir    = 2'b10;
      pend     = {4'b0000, 2'b10, 1'b0};
   endfunction

   function automatic void model_step(input bit [4:0] raw, input bit go);
      int  nxt;
      bit  any_rise;
      bit  bomb;
      nxt      = m_active;
      any_rise = 0;
      for (int i = 0; i < 4; i++)
         if (m_rise[i] && !any_rise) begin nxt = i; any_rise = 1; end
      if (!any_rise && m_active >= 0 && m_fall[m_active]) begin
         nxt = -1;
         for (int i = 0; i < 4; i++)
            if (m_stable[i] && nxt < 0) nxt = i;
      end
      m_active = nxt;
      bomb = BOMB && !go && m_rise[4];
      if (!go && nxt >= 0) m_dir = 2'(nxt);
      pend = {!go && nxt == 3, !go && nxt == 1, !go && nxt == 0, !go && nxt == 2, m_dir, bomb};
      // A new level is accepted once the synchronised input has differed for DB cycles in a row.
      for (int b = 0; b < 5; b++) begin
         m_rise[b] = 0;
         m_fall[b] = 0;
         if (m_d2[b] == m_stable[b]) m_run[b] = 0;
         else if (m_run[b] + 1 == DB) begin
            m_stable[b] = m_d2[b];
            m_run[b]    = 0;
            m_rise[b]   = m_d2[b];
            m_fall[b]   = !m_d2[b];
         end else m_run[b] = m_run[b] + 1;
         m_d2[b] = m_d1[b];
         m_d1[b] = raw[b];
      end
   endfunction

   task automatic drive(input bit [4:0] b, input bit go, input bit rst, input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.btn_u    = b[0];
         bus.btn_r    = b[1];
         bus.btn_d    = b[2];
         bus.btn_l    = b[3];
         bus.btn_c    = b[4];
         bus.gameover = go;
         reset        = rst;
         if (rst) model_reset();
         q.push_back(pend);
         if (!rst) model_step(b, go);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         exp_t a;
         e = q.pop_front();
         a = {bus.L, bus.R, bus.U, bus.D, bus.current_dir, bus.bomb_req};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL outs t=%0t LRUD_dir_bomb act=%b exp=%b", $time, a, e);
         end
      end
   end

   initial begin
      bus.btn_u = 0; bus.btn_r = 0; bus.btn_d = 0; bus.btn_l = 0; bus.btn_c = 0;
      bus.gameover = 0;
      model_reset();
      drive(5'd0, 0, 1, 3);
      drive(5'd0, 0, 0, 20);
      drive(BR, 0, 0, 10);
      drive(BR | BU, 0, 0, 3);
      drive(BR, 0, 0, 10);
      drive(BR | BU, 0, 0, 12);
      drive(BR, 0, 0, 12);
      drive(5'd0, 0, 0, 12);
      drive(BU | BL, 0, 0, 12);
      drive(5'd0, 0, 0, 12);
      drive(BR, 0, 0, 12);
      drive(BR, 1, 0, 4);
      drive(BR | BC, 1, 0, 12);
      drive(BR, 1, 0, 8);
      drive(BR, 0, 0, 4);
      drive(5'd0, 0, 0, 12);
      drive(BC, 0, 0, 100);
      drive(5'd0, 0, 0, 12);
      drive(BR, 0, 0, 3);
      drive(BR, 0, 1, 2);
      drive(BR, 0, 0, 12);
      drive(BL | BD, 0, 0, 4);
      drive(BL | BD, 0, 1, 1);
      drive(BL | BD, 0, 0, 12);
      drive(5'd0, 0, 0, 12);
      for (int p = 0; p < 300; p++) begin
         bit [4:0] b;
         bit       go;
         int       n;
         b  = 5'($urandom_range(0, 31));
         go = ($urandom_range(0, 9) == 0);
         n  = $urandom_range(1, 12);
         if ($urandom_range(0, 49) == 0) drive(b, go, 1, 1);
         drive(b, go, 0, n);
      end
      drive(5'd0, 0, 0, 12);
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain act=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
